// File: rtl/dense_vector_loader.sv
// dense_vector_loader: ping-pong staging of (activation, weight) frames plus bias for the dense-layer core.
module dense_vector_loader #(
   parameter int N = 64,
   parameter int W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_x,
   input  logic signed [W-1:0] in_w,
   input  logic signed [W-1:0] in_bias,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N-1:0][W-1:0] input_x,
   output logic [N-1:0][W-1:0] weights,
   output logic [W-1:0]        bias,
   output logic                err_len
);
   localparam int IW = $clog2(N);
   localparam int LW = $clog2(N + 1);
   logic [N-1:0][W-1:0] x_mem [2];
   logic [N-1:0][W-1:0] w_mem [2];
   logic [W-1:0]        b_mem [2];
   logic [LW-1:0]       len_mem [2];
   logic [IW-1:0]       wr_idx;
   logic                wr_ptr, rd_ptr;
   logic [1:0]          count, count_nxt;
   logic                acc, pop, commit, last_pos;
   assign acc       = in_valid && in_ready;
   assign last_pos  = wr_idx == IW'(N - 1);
   assign commit    = acc && (in_last || last_pos);
   assign out_valid = count != 2'd0;
   assign pop       = out_valid && out_ready;
   assign count_nxt = (commit && !pop) ? count + 2'd1 : (pop && !commit) ? count - 2'd1 : count;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            x_mem[b]   <= '0;
            w_mem[b]   <= '0;
            b_mem[b]   <= '0;
            len_mem[b] <= '0;
         end
         wr_idx   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         in_ready <= 1'b0;
         err_len  <= 1'b0;
      end else begin
         if (acc) begin
            x_mem[wr_ptr][wr_idx] <= in_x;
            w_mem[wr_ptr][wr_idx] <= in_w;
            if (wr_idx == '0) b_mem[wr_ptr] <= in_bias;
         end
         if (commit) begin
            len_mem[wr_ptr] <= LW'(wr_idx) + LW'(1);
            wr_idx          <= '0;
            wr_ptr          <= ~wr_ptr;
         end else if (acc) wr_idx <= wr_idx + 1'b1;
         if (pop) rd_ptr <= ~rd_ptr;
         count    <= count_nxt;
         in_ready <= count_nxt < 2'd2;
         // a length error is any commit where in_last and the index boundary disagree
         err_len  <= acc && (in_last != last_pos);
      end
   end
   always_comb begin
      for (int i = 0; i < N; i++) begin
         input_x[i] = (LW'(i) < len_mem[rd_ptr]) ? x_mem[rd_ptr][i] : '0;
         weights[i] = (LW'(i) < len_mem[rd_ptr]) ? w_mem[rd_ptr][i] : '0;
      end
      bias = b_mem[rd_ptr];
   end
endmodule

// File: tb/tb_dense_vector_loader.sv
// tb_dense_vector_loader: directed self-checking bench for dense_vector_loader.
module tb_dense_vector_loader;
   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0, in_ready, in_last = 1'b0;
   logic signed [31:0]   in_x = '0, in_w = '0, in_bias = '0;
   logic                 out_valid, out_ready = 1'b0, err_len;
   logic [63:0][31:0]    input_x, weights;
   logic [31:0]          bias;
   int checks = 0, errors = 0, err_cnt = 0, e0 = 0;

   dense_vector_loader #(.N(64), .W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .input_x(input_x), .weights(weights), .bias(bias), .err_len(err_len)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (err_len === 1'b1) err_cnt++;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic send(input int x, input int w, input int b, input bit last, input bit pop = 1'b0);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_x = x; in_w = w; in_bias = b; in_last = last; out_ready = pop;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n == 200) chk("send_timeout_in_ready", 32'(in_ready), 1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_input_x0", input_x[0], 0);
      chk("rst_weights63", weights[63], 0);
      chk("rst_bias", bias, 0);
      chk("rst_err_len", 32'(err_len), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // single frame, held with out_ready low
      e0 = err_cnt;
      for (int i = 0; i < 64; i++) send(i, 2, (i == 0) ? 7 : 99, i == 63);
      idle();
      chk("single_out_valid", 32'(out_valid), 1);
      chk("single_input_x5", input_x[5], 5);
      chk("single_weights63", weights[63], 2);
      chk("single_bias", bias, 7);
      chk("single_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      chk("single_stable_x5", input_x[5], 5);
      chk("single_no_err", err_cnt - e0, 0);

      // frame 2 commits in the same cycle the held frame pops
      for (int i = 0; i < 63; i++) send(100 + i, -i, (i == 0) ? -5 : 0, 1'b0);
      send(163, -63, 0, 1'b1, 1'b1);
      idle();
      chk("concur_out_valid", 32'(out_valid), 1);
      chk("concur_input_x0", input_x[0], 100);
      chk("concur_input_x63", input_x[63], 163);
      chk("concur_weights3", weights[3], -3);
      chk("concur_bias", bias, -5);
      chk("concur_in_ready", 32'(in_ready), 1);
      pop_one();
      chk("concur_drain_out_valid", 32'(out_valid), 0);

      // back-pressure with three frames
      for (int i = 0; i < 64; i++) send(1000 + i, 1, (i == 0) ? 11 : 0, i == 63);
      for (int i = 0; i < 64; i++) send(2000 + i, 2, (i == 0) ? 22 : 0, i == 63);
      @(negedge clk);
      in_valid = 1'b1; in_x = 3000; in_w = 3; in_bias = 33; in_last = 1'b0;
      chk("bp_in_ready_low", 32'(in_ready), 0);
      chk("bp_first_bias", bias, 11);
      chk("bp_first_x1", input_x[1], 1001);
      @(negedge clk);
      chk("bp_still_stalled", 32'(in_ready), 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_in_ready_back", 32'(in_ready), 1);
      chk("bp_second_bias", bias, 22);
      chk("bp_second_x63", input_x[63], 2063);
      @(posedge clk);
      for (int i = 1; i < 64; i++) send(3000 + i, 3, 0, i == 63);
      idle();
      chk("bp_full_again", 32'(in_ready), 0);
      pop_one();
      chk("bp_third_bias", bias, 33);
      chk("bp_third_x0", input_x[0], 3000);
      chk("bp_third_x63", input_x[63], 3063);
      chk("bp_third_in_ready", 32'(in_ready), 1);
      pop_one();
      chk("bp_empty", 32'(out_valid), 0);

      // early last at index 9
      for (int i = 0; i < 10; i++) send(-3, 4, (i == 0) ? 1 : 0, i == 9);
      idle();
      chk("early_err_len", 32'(err_len), 1);
      chk("early_x0", input_x[0], -3);
      chk("early_x9", input_x[9], -3);
      chk("early_x10", input_x[10], 0);
      chk("early_x63", input_x[63], 0);
      chk("early_w9", weights[9], 4);
      chk("early_w10", weights[10], 0);
      chk("early_bias", bias, 1);
      @(negedge clk);
      chk("early_err_one_cycle", 32'(err_len), 0);
      pop_one();

      // missing last: 64 elements commit, next ones start a new frame
      e0 = err_cnt;
      for (int i = 0; i < 64; i++) send(i, 1, (i == 0) ? 50 : 0, 1'b0);
      idle();
      chk("miss_err_len", 32'(err_len), 1);
      chk("miss_out_valid", 32'(out_valid), 1);
      chk("miss_x63", input_x[63], 63);
      chk("miss_bias", bias, 50);
      for (int i = 64; i < 70; i++) send(i, 1, (i == 64) ? 60 : 0, 1'b0);
      idle();
      @(negedge clk);
      chk("miss_one_err", err_cnt - e0, 1);
      pop_one();
      chk("miss_partial_not_valid", 32'(out_valid), 0);
      send(70, 1, 0, 1'b1);
      idle();
      chk("miss_f2_x0", input_x[0], 64);
      chk("miss_f2_x5", input_x[5], 69);
      chk("miss_f2_x6", input_x[6], 70);
      chk("miss_f2_x7", input_x[7], 0);
      chk("miss_f2_bias", bias, 60);
      pop_one();

      // reset mid-frame with one full bank pending
      for (int i = 0; i < 64; i++) send(i, 1, 8, i == 63);
      for (int i = 0; i < 30; i++) send(500, 1, 0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_out_valid", 32'(out_valid), 0);
      chk("mrst_input_x0", input_x[0], 0);
      chk("mrst_weights0", weights[0], 0);
      chk("mrst_bias", bias, 0);
      chk("mrst_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_rel_in_ready", 32'(in_ready), 1);
      chk("mrst_rel_out_valid", 32'(out_valid), 0);
      for (int i = 0; i < 64; i++) send(2 * i, i - 32, -9, i == 63);
      idle();
      chk("mrst_new_valid", 32'(out_valid), 1);
      chk("mrst_new_x1", input_x[1], 2);
      chk("mrst_new_x63", input_x[63], 126);
      chk("mrst_new_w0", weights[0], -32);
      chk("mrst_new_bias", bias, -9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dense_vector_loader.md
# dense_vector_loader

Ping-pong staging buffer directly upstream of the dense-layer neuron core. Accepts a stream of (activation, weight) element pairs over a valid/ready handshake, packs each frame of N pairs plus one bias into a bank, and presents the full 64-element vectors and bias to the core as parallel arrays. Two banks let bank B fill while the core consumes bank A.

## Interface
- N, 64, elements per frame (vector length presented to the core)
- W, 32, signed element width for activations, weights and bias
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  element pair present on in_x/in_w
- in_ready  out  1  loader can accept an element this cycle
- in_x  in  W  signed activation element
- in_w  in  W  signed weight element
- in_bias  in  W  signed bias; sampled only on the accepted element with index 0
- in_last  in  1  marks final element of a frame
- out_valid  out  1  a complete frame is presented
- out_ready  in  1  core consumes the presented frame
- input_x  out  N×W  activation vector, element i at index i
- weights  out  N×W  weight vector, element i at index i
- bias  out  W  bias of the presented frame
- err_len  out  1  one-cycle pulse on a frame-length violation

## Operation
- Accept: in_valid && in_ready. Accepted pair written to write bank at index wr_idx; wr_idx increments.
- wr_idx 0: in_bias also captured into that bank.
- Commit: on the accept where in_last=1 or wr_idx=N-1. Bank stores length len = wr_idx+1; wr_idx returns to 0; write-bank pointer toggles; full count +1.
- Early last (in_last at wr_idx<N-1): commit with len<N; elements at index ≥len read as 0; err_len pulses.
- Missing last (wr_idx=N-1, in_last=0): commit normally (len=N); err_len pulses. The next accepted element starts a new frame at index 0.
- Pop: out_valid && out_ready. Read-bank pointer toggles; full count −1.
- Full count 0..2. in_ready = (count<2). out_valid = (count>0).
- Simultaneous commit and pop: count unchanged; both pointers toggle.
- Output arrays driven from the read bank, masked by that bank's len. When out_valid=0, contents are unspecified but held stable.
- Reset: wr_idx 0, both pointers to bank 0, count 0, all bank data and len cleared to 0.

## Timing
- Reset values: in_ready 0 while rst is high, 1 from the first cycle after release; out_valid 0; input_x, weights, bias all 0; err_len 0.
- Reset asserted mid-frame discards partial and full banks immediately. No frame is presented after release.
- Latency: commit in cycle t gives out_valid=1 in cycle t+1 when the count was 0. Arrays are valid in the same cycle as out_valid.
- in_ready updates registered: it falls the cycle after the second bank commits (unless popped that cycle). It rises the cycle after a pop from count 2.
- Throughput: one element per cycle sustained when out_ready is pulsed at least once per N cycles. No bubble between frames.
- Output arrays and bias are stable while out_valid=1 && out_ready=0.
- err_len asserts in the cycle after the offending accept, for exactly one cycle.
- in_x, in_w, in_bias, in_last are ignored when in_valid=0 or in_ready=0.

## Test plan
- Single frame: x[i]=i, w[i]=2, bias=7, last at i=63, out_ready=0. Expect out_valid the next cycle, input_x[5]=5, weights[63]=2, bias=7, in_ready stays 1, err_len never pulses.
- Back-pressure: three frames streamed back-to-back, out_ready=0. Expect in_ready=0 after frame 2 commits and frame 3 element 0 stalled. Pop once; in_ready returns next cycle. Frames emerge in order 1, 2, 3 with their biases.
- Concurrent commit/pop: count=1 and frame 2 committing in the same cycle as out_ready=1. Expect out_valid stays 1 and the presented frame switches to frame 2 next cycle.
- Early last: 10 elements, x=−3, last at index 9. Expect input_x[0..9]=−3, input_x[10..63]=0, weights[10..63]=0, one err_len pulse.
- Missing last: 70 elements, in_last never asserted. Expect frame 1 committed at element 64 with one err_len pulse, and the next 6 elements land at indices 0..5 of frame 2.
- Reset mid-frame: rst high after 30 accepted elements with one full bank pending. Expect out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and a new 64-element frame is presented correctly.
